// File: rtl/framebuffer_page_ctrl.sv
// framebuffer_page_ctrl: double-buffer page flip with frame-synced swap, timeout fallback and post-swap clear
module framebuffer_page_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_ADDR_WIDTH = 11,
  parameter SWAP_TIMEOUT = 20'd727273,
  parameter int TIMEOUT_WIDTH = 20,
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic clk_in,
  input  logic reset,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [7:0] ctrl_data,
  input  logic ctrl_we,
  input  logic ctrl_clk_en,
  input  logic swap_req,
  input  logic swap_clear,
  input  logic frame_end,
  input  logic [RD_ADDR_WIDTH-1:0] fetch_addr,
  output logic [ADDR_WIDTH:0] ram_a_addr,
  output logic [7:0] ram_a_data,
  output logic ram_a_we,
  output logic ram_a_clk_en,
  output logic [RD_ADDR_WIDTH:0] ram_b_addr,
  output logic front_bank,
  output logic swap_pending,
  output logic swap_done,
  output logic swap_forced,
  output logic wr_ready,
  output logic [7:0] dropped_writes
);
  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(SWAP_TIMEOUT - 1);
  state_t state, next_state;
  logic clr_flag;
  logic swap_fire;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  logic [ADDR_WIDTH-1:0] clear_cnt;
  always_comb begin
    next_state = state;
    swap_fire = 1'b0;
    case (state)
      IDLE: next_state = swap_req ? PENDING : IDLE;
      PENDING: begin
        swap_fire = frame_end || tcnt == TO_LAST;
        next_state = swap_fire ? (clr_flag ? CLEAR : IDLE) : PENDING;
      end
      CLEAR: next_state = &clear_cnt ? IDLE : CLEAR;
      default: next_state = IDLE;
    endcase
  end
  assign swap_pending = state == PENDING;
  assign swap_done = swap_fire;
  assign swap_forced = swap_fire && !frame_end;
  assign wr_ready = state != CLEAR;
  assign ram_b_addr = {front_bank, fetch_addr};
  always_ff @(posedge clk_in) state <= reset ? IDLE : next_state;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      front_bank <= 1'b0;
      clr_flag <= 1'b0;
      tcnt <= '0;
      clear_cnt <= '0;
      ram_a_addr <= '0;
      ram_a_data <= '0;
      ram_a_we <= 1'b0;
      ram_a_clk_en <= 1'b0;
      dropped_writes <= '0;
    end else begin
      if (state == IDLE && swap_req) begin
        clr_flag <= swap_clear;
        tcnt <= '0;
      end else if (state == PENDING) begin
        tcnt <= tcnt + 1'b1;
      end
      if (swap_fire) front_bank <= ~front_bank;
      // the clear engine owns port A; control_module writes are discarded and counted
      if (state == CLEAR) begin
        ram_a_addr <= {~front_bank, clear_cnt};
        ram_a_data <= CLEAR_VALUE;
        ram_a_we <= 1'b1;
        ram_a_clk_en <= 1'b1;
        clear_cnt <= clear_cnt + 1'b1;
      end else begin
        ram_a_addr <= {~front_bank, ctrl_addr};
        ram_a_data <= ctrl_data;
        ram_a_we <= ctrl_we;
        ram_a_clk_en <= ctrl_clk_en;
      end
      if (ctrl_we && !wr_ready && dropped_writes != 8'hFF) dropped_writes <= dropped_writes + 1'b1;
    end
  end
endmodule

// File: tb/tb_framebuffer_page_ctrl.sv
// tb_framebuffer_page_ctrl: directed and random stimulus checked against a cycle-level behavioural model
module tb_framebuffer_page_ctrl;
  localparam int AW = 4;
  localparam int RAW = 11;
  localparam int TO = 100;
  localparam logic [7:0] CV = 8'hC3;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] ctrl_addr = '0;
  logic [7:0] ctrl_data = '0;
  logic ctrl_we = 1'b0, ctrl_clk_en = 1'b0, swap_req = 1'b0, swap_clear = 1'b0, frame_end = 1'b0;
  logic [RAW-1:0] fetch_addr = '0;
  logic [AW:0] ram_a_addr;
  logic [7:0] ram_a_data;
  logic ram_a_we, ram_a_clk_en;
  logic [RAW:0] ram_b_addr;
  logic front_bank, swap_pending, swap_done, swap_forced, wr_ready;
  logic [7:0] dropped_writes;
  int n_cmp = 0, n_bad = 0;
  bit m_pend, m_clr_want, m_bank;
  int m_age, m_clear_left, m_drops;
  logic [AW:0] m_a_addr;
  logic [7:0] m_a_data;
  bit m_a_we, m_a_en;

  always #5 clk_in = ~clk_in;

  framebuffer_page_ctrl #(
    .ADDR_WIDTH(AW), .RD_ADDR_WIDTH(RAW), .SWAP_TIMEOUT(TO), .TIMEOUT_WIDTH(20), .CLEAR_VALUE(CV)
  ) dut (
    .clk_in(clk_in), .reset(reset), .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data),
    .ctrl_we(ctrl_we), .ctrl_clk_en(ctrl_clk_en), .swap_req(swap_req), .swap_clear(swap_clear),
    .frame_end(frame_end), .fetch_addr(fetch_addr), .ram_a_addr(ram_a_addr), .ram_a_data(ram_a_data),
    .ram_a_we(ram_a_we), .ram_a_clk_en(ram_a_clk_en), .ram_b_addr(ram_b_addr), .front_bank(front_bank),
    .swap_pending(swap_pending), .swap_done(swap_done), .swap_forced(swap_forced),
    .wr_ready(wr_ready), .dropped_writes(dropped_writes)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ctrl_we = 1'b0;
    ctrl_clk_en = 1'b0;
    swap_req = 1'b0;
    swap_clear = 1'b0;
    frame_end = 1'b0;
  endtask

  // one clock: compare every output against the model, then advance the model across the edge
  task automatic step();
    bit fire, clearing;
    fire = m_pend && (frame_end || m_age == TO - 1);
    clearing = m_clear_left > 0;
    #1;
    check("ram_b_addr", 32'(ram_b_addr), 32'({m_bank, fetch_addr}));
    check("swap_pending", 32'(swap_pending), 32'(m_pend));
    check("swap_done", 32'(swap_done), 32'(fire));
    check("swap_forced", 32'(swap_forced), 32'(fire && !frame_end));
    check("wr_ready", 32'(wr_ready), 32'(!clearing));
    check("front_bank", 32'(front_bank), 32'(m_bank));
    check("ram_a_addr", 32'(ram_a_addr), 32'(m_a_addr));
    check("ram_a_data", 32'(ram_a_data), 32'(m_a_data));
    check("ram_a_we", 32'(ram_a_we), 32'(m_a_we));
    check("ram_a_clk_en", 32'(ram_a_clk_en), 32'(m_a_en));
    check("dropped_writes", 32'(dropped_writes), 32'(m_drops));
    @(posedge clk_in);
    if (reset) begin
      m_pend = 0; m_clr_want = 0; m_bank = 0; m_age = 0; m_clear_left = 0; m_drops = 0;
      m_a_addr = '0; m_a_data = '0; m_a_we = 0; m_a_en = 0;
    end else begin
      if (ctrl_we && clearing && m_drops < 255) m_drops++;
      if (clearing) begin
        m_a_addr = {~m_bank, AW'((1 << AW) - m_clear_left)};
        m_a_data = CV; m_a_we = 1; m_a_en = 1;
        m_clear_left--;
      end else begin
        m_a_addr = {~m_bank, ctrl_addr};
        m_a_data = ctrl_data; m_a_we = ctrl_we; m_a_en = ctrl_clk_en;
      end
      if (fire) begin
        m_pend = 0;
        m_bank = ~m_bank;
        if (m_clr_want) m_clear_left = 1 << AW;
      end else if (m_pend) begin
        m_age++;
      end else if (!clearing && swap_req) begin
        m_pend = 1; m_age = 0; m_clr_want = swap_clear;
      end
    end
    @(negedge clk_in);
  endtask

  initial begin
    @(negedge clk_in);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_front", 32'(front_bank), 0);
    check("rst_ready", 32'(wr_ready), 1);
    ctrl_addr = 4'h3; ctrl_data = 8'hAB; ctrl_we = 1'b1; ctrl_clk_en = 1'b1; fetch_addr = 11'h005;
    step();
    check("pass_addr", 32'(ram_a_addr), 32'h13);
    check("pass_data", 32'(ram_a_data), 32'hAB);
    check("pass_we", 32'(ram_a_we), 1);
    check("pass_b_addr", 32'(ram_b_addr), 32'h005);
    idle_inputs();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      check("sync_pending", 32'(swap_pending), 1);
      step();
    end
    frame_end = 1'b1;
    #1;
    check("sync_done", 32'(swap_done), 1);
    check("sync_forced", 32'(swap_forced), 0);
    step();
    frame_end = 1'b0;
    check("sync_front", 32'(front_bank), 1);
    check("sync_b_msb", 32'(ram_b_addr[RAW]), 1);
    ctrl_addr = '0; ctrl_we = 1'b1;
    step();
    check("sync_wr_bank0", 32'(ram_a_addr), 0);
    idle_inputs();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (TO - 1) step();
    #1;
    check("to_done", 32'(swap_done), 1);
    check("to_forced", 32'(swap_forced), 1);
    step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (TO - 1) step();
    frame_end = 1'b1;
    #1;
    check("to_fe_done", 32'(swap_done), 1);
    check("to_fe_forced", 32'(swap_forced), 0);
    step();
    frame_end = 1'b0;
    swap_req = 1'b1; swap_clear = 1'b1;
    step();
    swap_req = 1'b0; swap_clear = 1'b0; frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      ctrl_we = i < 5;
      check("clr_busy", 32'(wr_ready), 0);
      step();
      check("clr_addr", 32'(ram_a_addr), 32'((1 << AW) + i));
      check("clr_data", 32'(ram_a_data), 32'(CV));
      check("clr_we", 32'(ram_a_we), 1);
      check("clr_ready", 32'(wr_ready), 32'(i == (1 << AW) - 1));
    end
    ctrl_we = 1'b0;
    check("clr_dropped", 32'(dropped_writes), 5);
    repeat (20) begin
      ctrl_we = 1'b1; swap_req = 1'b1; swap_clear = 1'b1;
      step();
      swap_req = 1'b0; swap_clear = 1'b0; frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      repeat (1 << AW) step();
    end
    idle_inputs();
    check("sat_dropped", 32'(dropped_writes), 32'hFF);
    swap_req = 1'b1;
    step();
    step();
    swap_req = 1'b0;
    step();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    repeat (3) step();
    check("merge_front", 32'(front_bank), 1);
    check("merge_pending", 32'(swap_pending), 0);
    swap_req = 1'b1; swap_clear = 1'b1;
    step();
    swap_req = 1'b0; swap_clear = 1'b0; frame_end = 1'b1;
    step();
    frame_end = 1'b0; ctrl_we = 1'b1;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ctrl_we = 1'b0;
    check("abort_ready", 32'(wr_ready), 1);
    check("abort_front", 32'(front_bank), 0);
    check("abort_we", 32'(ram_a_we), 0);
    check("abort_dropped", 32'(dropped_writes), 0);
    check("abort_pending", 32'(swap_pending), 0);
    repeat (3000) begin
      reset = $urandom_range(0, 399) == 0;
      ctrl_addr = AW'($urandom);
      ctrl_data = 8'($urandom);
      ctrl_we = 1'($urandom);
      ctrl_clk_en = 1'($urandom);
      swap_req = $urandom_range(0, 29) == 0;
      swap_clear = 1'($urandom);
      frame_end = $urandom_range(0, 59) == 0;
      fetch_addr = RAW'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
